bullet_judge: RTL and testbench
===============================

// Module: bullet_judge
// PURPOSE
// Player-bullet manager feeding the top-level pixel priority mux (mybullet_en / mybullet_rgb).
// Keeps a pool of bullet slots: spawns above the player plane on fire, moves them up each
// movement tick and retires them at screen top or on enemy hit.
// Per pixel it reports whether (x,y) lies inside any live bullet and gives that pixel's colour.
// PARAMETERS
// N_SLOTS    4       bullet pool size (1..8)
// BULLET_W   4       bullet width, pixels
// BULLET_H   8       bullet height, pixels
// SPEED      4       pixels moved upward per movement tick
// COOLDOWN   20      movement ticks between consecutive spawns
// PLANE_W    32      player plane width, used for the centred spawn x
// ENEMY_W    32      enemy hitbox width
// ENEMY_H    32      enemy hitbox height
// COLOR      12'hFF0 bullet RGB444 colour
// PORTS
// clk           in   1   pixel clock (25.175 MHz); all logic on posedge
// rst           in   1   asynchronous active-low reset
// clk_move      in   1   slow 10 ms movement strobe (level); synchronised internally, rising edge = tick
// fire          in   1   fire button level (async); synchronised internally
// boom          in   1   player destroyed; clears pool and blocks spawning while high
// p_x, p_y      in   10  player plane top-left
// enemy_x/_y    in   10  enemy top-left
// enemy_alive   in   1   enemy hitbox valid
// x, y          in   10  current scan pixel from the VGA timing block
// EN            out  1   pixel (x,y) inside a live bullet (registered)
// rgb           out  12  COLOR when EN, else 12'h000 (registered)
// hit           out  1   one-cycle pulse: at least one bullet struck the enemy this tick
// BEHAVIOUR
// - Reset (rst=0, async): all slots inactive, cooldown=0, sync flops=0, EN=0, rgb=0, hit=0.
// - Sync: clk_move and fire each pass through 2 flops; tick = 1-cycle pulse on synced clk_move rise.
// - Slot state: active bit, bx[9:0], by[9:0]. All updates happen only in the tick cycle.
// - Tick processing order, all in the same cycle:
//   1 Move: each active slot with by >= SPEED gets by -= SPEED; by < SPEED -> inactive (no wrap).
//   2 Collide: enemy_alive and a moved slot overlaps the enemy box -> slot inactive; hit=1 next cycle.
//     Overlap is strict AABB: bx<ex+ENEMY_W && ex<bx+BULLET_W && by<ey+ENEMY_H && ey<by+BULLET_H.
//     Every overlapping slot retires; hit is still a single pulse.
//   3 Spawn: fire_s && !boom && cooldown==0 && p_y>=BULLET_H && a free slot exists.
//     The free slot is judged after steps 1-2. The lowest-index free slot loads
//     bx = p_x+PLANE_W/2-BULLET_W/2 and by = p_y-BULLET_H, then cooldown = COOLDOWN.
//     A newly spawned slot neither moves nor collides until the next tick.
//   4 Otherwise: cooldown>0 -> cooldown-1. The decrement also happens when a spawn was blocked.
// - Pool full: fire is ignored and cooldown is unchanged. Spawn x arithmetic is 10-bit; no clamp.
// - boom=1: all slots cleared on the next clk edge regardless of tick; spawning is inhibited.
//   Cooldown still counts.
// - Pixel path, 1-cycle latency to match the background ROM:
//   EN <= OR over active slots of (x in [bx,bx+BULLET_W) && y in [by,by+BULLET_H)).
//   rgb <= that hit ? COLOR : 0.
//   Pixel evaluation uses slot state before the current edge's update.
// - hit: asserted exactly the cycle after the tick cycle, otherwise 0.
// STRUCTURE
// - Shared include game_defs.vh: SCREEN_W=640, SCREEN_H=480, COORD_W=10, colour constants.
//   The top-level mux and the other *_Judge blocks use the same file.
// - Sub-module tick_sync: 2-flop synchroniser plus rising-edge pulse. Instantiated twice:
//   clk_move gives the tick; fire is used as level only.
// - Slot pool is an N_SLOTS-wide register array. The free-slot priority encoder and the
//   per-slot move, collide and pixel compare use generate loops.
// TESTING
// - Reset mid-flight: 2 slots live, pull rst low async -> EN=0, rgb=0, hit=0 at once; no spawn until fire.
// - Spawn: p=(300,400), fire held, 1 tick -> slot0 at (314,392); scan (314,392) -> EN=1, rgb=FF0 one cycle later.
//   Scan (318,392) -> EN=0.
// - Cooldown/full: fire held 200 ticks, COOLDOWN=20, no enemy.
//   Spawns occur on ticks 1, 22, 43 ... and at most 4 slots are ever active.
// - Top exit: slot at by=6, SPEED=4 -> by=2 next tick; following tick -> inactive, EN never set at y>=470.
// - Hit: enemy (310,360) alive, bullet reaches by<=391 overlap -> slot freed, hit high exactly 1 cycle.
//   Two overlapping bullets in the same tick -> both freed, one pulse.
// - boom: 3 slots live, boom=1 -> all cleared next cycle; fire held with boom -> no spawn until boom=0.

Source files
------------

// File: rtl/bullet_judge_pkg.sv
// Shared definitions for the player-bullet manager.
//   coord_t  : 10-bit screen coordinate
//   slot_t   : one bullet slot (live flag plus top-left corner)
//   lt_sum   : a < b + len, evaluated one bit wider so the sum never wraps
//   in_span  : p lies in the half-open interval [lo, lo+len)
package bullet_judge_pkg;

  localparam int COORD_W = 10;
  localparam logic [11:0] RGB_BLACK = 12'h000;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    logic   active;
    coord_t bx;
    coord_t by;
  } slot_t;

  function automatic logic lt_sum(input coord_t a, input coord_t b,
                                  input logic [COORD_W:0] len);
    return {1'b0, a} < ({1'b0, b} + len);
  endfunction

  function automatic logic in_span(input coord_t p, input coord_t lo,
                                   input logic [COORD_W:0] len);
    return (p >= lo) && lt_sum(p, lo, len);
  endfunction

endpackage

// File: rtl/bullet_judge_tick_sync.sv
// Two-flop synchroniser followed by a rising-edge detector.
//   clk      : pixel clock
//   rst      : asynchronous active-low reset
//   async_in : asynchronous level input
//   level    : synchronised level
//   rise     : one-cycle pulse on a synchronised 0->1 transition
module tick_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise
);

  // [0],[1] are the synchroniser; [2] remembers the previous synced level.
  logic [2:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[1:0], async_in};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= sync_d;
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/bullet_judge.sv
// Player-bullet manager: keeps a pool of bullet slots, spawns above the
// player on fire, moves them upward every movement tick, retires them at the
// top of the screen or on contact with the enemy, and reports per pixel
// whether the scan position lies inside a live bullet.
//   clk, rst          : pixel clock, asynchronous active-low reset
//   clk_move, fire    : asynchronous levels (movement strobe, fire button)
//   boom              : player destroyed; clears the pool, blocks spawning
//   p_x, p_y          : player top-left
//   enemy_x/_y/_alive : enemy hitbox
//   x, y              : current scan pixel
//   EN, rgb           : registered pixel hit and colour
//   hit               : one-cycle pulse, the cycle after a tick with a strike
module bullet_judge
  import bullet_judge_pkg::*;
#(
  parameter int          N_SLOTS  = 4,
  parameter int          BULLET_W = 4,
  parameter int          BULLET_H = 8,
  parameter int          SPEED    = 4,
  parameter int          COOLDOWN = 20,
  parameter int          PLANE_W  = 32,
  parameter int          ENEMY_W  = 32,
  parameter int          ENEMY_H  = 32,
  parameter logic [11:0] COLOR    = 12'hFF0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clk_move,
  input  logic               fire,
  input  logic               boom,
  input  logic [COORD_W-1:0] p_x,
  input  logic [COORD_W-1:0] p_y,
  input  logic [COORD_W-1:0] enemy_x,
  input  logic [COORD_W-1:0] enemy_y,
  input  logic               enemy_alive,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  output logic               EN,
  output logic [11:0]        rgb,
  output logic               hit
);

  localparam int CD_W = (COOLDOWN > 1) ? $clog2(COOLDOWN + 1) : 1;

  localparam logic [COORD_W:0] BW_L = (COORD_W + 1)'(BULLET_W);
  localparam logic [COORD_W:0] BH_L = (COORD_W + 1)'(BULLET_H);
  localparam logic [COORD_W:0] EW_L = (COORD_W + 1)'(ENEMY_W);
  localparam logic [COORD_W:0] EH_L = (COORD_W + 1)'(ENEMY_H);
  localparam coord_t SPEED_C  = COORD_W'(SPEED);
  localparam coord_t BH_C     = COORD_W'(BULLET_H);
  localparam coord_t SPAWN_DX = COORD_W'(PLANE_W / 2 - BULLET_W / 2);

  logic tick, fire_s, fire_rise_unused;

  tick_sync u_move_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (clk_move),
    .level    (),
    .rise     (tick)
  );

  tick_sync u_fire_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (fire),
    .level    (fire_s),
    .rise     (fire_rise_unused)
  );

  // kept : slot still live after move and collide
  // coll : slot struck the enemy this tick
  // sel  : one-hot lowest-index slot that is free after move and collide
  // pix  : scan pixel inside this slot (pre-update state)
  logic [N_SLOTS-1:0] kept, coll, sel, pix;
  logic               spawn;
  coord_t             spawn_x, spawn_y;
  logic [CD_W-1:0]    cd_q, cd_d;
  logic               hit_q, hit_d, en_q, en_d;
  logic [11:0]        rgb_q, rgb_d;

  assign spawn   = tick && fire_s && !boom && (cd_q == '0) && (p_y >= BH_C) && (|sel);
  assign spawn_x = p_x + SPAWN_DX;   // 10-bit wrap, no clamp
  assign spawn_y = p_y - BH_C;

  genvar gi;
  generate
    for (gi = 0; gi < N_SLOTS; gi++) begin : gen_slot
      slot_t slot_q, slot_d, moved;

      always_comb begin
        moved = slot_q;
        if (slot_q.active) begin
          if (slot_q.by >= SPEED_C) moved.by = slot_q.by - SPEED_C;
          else                      moved.active = 1'b0;   // leaves the top, no wrap
        end
      end

      assign coll[gi] = moved.active && enemy_alive &&
                        lt_sum(moved.bx, enemy_x, EW_L) && lt_sum(enemy_x, moved.bx, BW_L) &&
                        lt_sum(moved.by, enemy_y, EH_L) && lt_sum(enemy_y, moved.by, BH_L);
      assign kept[gi] = moved.active && !coll[gi];

      assign pix[gi] = slot_q.active && in_span(x, slot_q.bx, BW_L) &&
                       in_span(y, slot_q.by, BH_L);

      if (gi == 0) begin : gen_sel_first
        assign sel[gi] = !kept[gi];
      end else begin : gen_sel_rest
        assign sel[gi] = !kept[gi] && (&kept[gi-1:0]);
      end

      always_comb begin
        slot_d = slot_q;
        if (boom) begin
          slot_d.active = 1'b0;
        end else if (tick) begin
          slot_d        = moved;
          slot_d.active = kept[gi];
          // A freshly spawned slot skips move/collide until the next tick.
          if (spawn && sel[gi]) begin
            slot_d.active = 1'b1;
            slot_d.bx     = spawn_x;
            slot_d.by     = spawn_y;
          end
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) slot_q <= '0;
        else      slot_q <= slot_d;
      end
    end
  endgenerate

  // Cooldown only moves on ticks; a blocked spawn still decrements it.
  always_comb begin
    cd_d = cd_q;
    if (tick) begin
      if (spawn)             cd_d = CD_W'(COOLDOWN);
      else if (cd_q != '0)   cd_d = cd_q - 1'b1;
    end
  end

  always_comb begin
    hit_d = tick && (|coll);
    en_d  = |pix;
    rgb_d = en_d ? COLOR : RGB_BLACK;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cd_q  <= '0;
      hit_q <= 1'b0;
      en_q  <= 1'b0;
      rgb_q <= RGB_BLACK;
    end else begin
      cd_q  <= cd_d;
      hit_q <= hit_d;
      en_q  <= en_d;
      rgb_q <= rgb_d;
    end
  end

  assign EN  = en_q;
  assign rgb = rgb_q;
  assign hit = hit_q;

endmodule

// File: tb/tb_bullet_judge.sv
module tb_bullet_judge;

  logic        clk = 1'b0, rst = 1'b0;
  logic        clk_move = 1'b0, fire = 1'b0, boom = 1'b0, enemy_alive = 1'b0;
  logic [9:0]  p_x = '0, p_y = '0, enemy_x = '0, enemy_y = '0, x = '0, y = '0;
  logic        EN, hit;
  logic [11:0] rgb;

  bullet_judge dut (
    .clk(clk), .rst(rst), .clk_move(clk_move), .fire(fire), .boom(boom),
    .p_x(p_x), .p_y(p_y), .enemy_x(enemy_x), .enemy_y(enemy_y),
    .enemy_alive(enemy_alive), .x(x), .y(y), .EN(EN), .rgb(rgb), .hit(hit)
  );

  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  // Reference model: bullet list with plain integer coordinates.
  bit m_act[4];
  int m_bx[4], m_by[4];
  int m_cd = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) m_act[i] = 0;
  endtask

  function automatic bit model_pix(int px, int py);
    for (int i = 0; i < 4; i++)
      if (m_act[i] && px >= m_bx[i] && px < m_bx[i] + 4 && py >= m_by[i] && py < m_by[i] + 8)
        return 1;
    return 0;
  endfunction

  task automatic model_tick(output bit h);
    int ex, ey, fs;
    ex = int'(enemy_x); ey = int'(enemy_y); h = 0; fs = -1;
    if (boom) model_clear();
    for (int i = 0; i < 4; i++) begin
      if (m_act[i]) begin
        if (m_by[i] >= 4) m_by[i] -= 4;
        else m_act[i] = 0;
        if (m_act[i] && enemy_alive && m_bx[i] < ex + 32 && ex < m_bx[i] + 4 &&
            m_by[i] < ey + 32 && ey < m_by[i] + 8) begin
          m_act[i] = 0;
          h = 1;
        end
      end
    end
    for (int i = 3; i >= 0; i--) if (!m_act[i]) fs = i;
    if (fire && !boom && m_cd == 0 && int'(p_y) >= 8 && fs >= 0) begin
      m_act[fs] = 1;
      m_bx[fs]  = (int'(p_x) + 14) % 1024;
      m_by[fs]  = int'(p_y) - 8;
      m_cd      = 20;
    end else if (m_cd > 0) begin
      m_cd--;
    end
  endtask

  task automatic scan(input int px, input int py, input string tag);
    bit e;
    @(negedge clk);
    x = 10'(px); y = 10'(py);
    @(posedge clk); #1;
    e = model_pix(px, py);
    check({tag, "_en"}, 32'(EN), 32'(e));
    check({tag, "_rgb"}, 32'(rgb), e ? 32'hFF0 : 32'h0);
  endtask

  task automatic do_tick();
    bit eh;
    int hits = 0;
    repeat (3) @(negedge clk);   // let fire/inputs settle through the synchroniser
    model_tick(eh);
    clk_move = 1'b1;
    repeat (8) begin @(posedge clk); #1; if (hit === 1'b1) hits++; end
    @(negedge clk);
    clk_move = 1'b0;
    repeat (4) begin @(posedge clk); #1; if (hit === 1'b1) hits++; end
    $display("tick: fire=%0b boom=%0b p=(%0d,%0d) enemy=(%0d,%0d,%0b) hit_cycles=%0d",
             fire, boom, p_x, p_y, enemy_x, enemy_y, enemy_alive, hits);
    check("hit_pulses", 32'(hits), 32'(eh));
  endtask

  task automatic check_all();
    for (int i = 0; i < 4; i++) begin
      if (m_act[i]) begin
        scan(m_bx[i], m_by[i], "slot_tl");
        scan((m_bx[i] + 3) % 1024, m_by[i] + 7, "slot_br");
        scan((m_bx[i] + 4) % 1024, m_by[i], "slot_right");
      end
    end
    if (int'(p_y) >= 8) scan((int'(p_x) + 14) % 1024, int'(p_y) - 8, "spawn_pt");
    scan($urandom_range(0, 1023), $urandom_range(0, 1023), "rand_px");
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk); rst = 1'b1;
    model_clear(); m_cd = 0;
  endtask

  task automatic set_boom(input logic v);
    @(negedge clk); boom = v;
    @(posedge clk); #1;
    if (v) model_clear();
  endtask

  initial begin
    // Power-up reset
    #1;
    check("rst_en", 32'(EN), 0);
    check("rst_rgb", 32'(rgb), 0);
    check("rst_hit", 32'(hit), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // Directed spawn
    p_x = 300; p_y = 400; fire = 1'b1;
    do_tick();
    scan(314, 392, "spawn_hit");
    check("spawn_en_const", 32'(EN), 1);
    check("spawn_rgb_const", 32'(rgb), 32'hFF0);
    scan(318, 392, "spawn_right_edge");
    check("spawn_edge_const", 32'(EN), 0);
    scan(313, 392, "spawn_left_edge");
    scan(317, 399, "spawn_bottom_in");
    scan(317, 400, "spawn_bottom_out");

    // Cooldown / pool full / top exit with fire held
    for (int t = 0; t < 110; t++) begin
      do_tick();
      check_all();
    end

    // Reset mid-flight while a bullet pixel is being scanned
    fire = 1'b0;
    for (int i = 3; i >= 0; i--) if (m_act[i]) begin x = 10'(m_bx[i]); y = 10'(m_by[i]); end
    @(posedge clk); #1;
    check("pre_rst_en", 32'(EN), 32'(model_pix(int'(x), int'(y))));
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check("midrst_en", 32'(EN), 0);
    check("midrst_rgb", 32'(rgb), 0);
    check("midrst_hit", 32'(hit), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_clear(); m_cd = 0;
    repeat (3) begin do_tick(); check_all(); end

    // Top exit from by=6
    p_x = 100; p_y = 14; fire = 1'b1;
    do_tick(); check_all();
    fire = 1'b0;
    do_tick(); check_all();
    scan(114, 2, "top_by2");
    do_tick(); check_all();
    scan(114, 2, "top_gone");

    // Single hit
    do_reset();
    p_x = 300; p_y = 400; enemy_x = 310; enemy_y = 360; enemy_alive = 1'b0; fire = 1'b1;
    do_tick(); check_all();
    fire = 1'b0; enemy_alive = 1'b1;
    do_tick(); check_all();

    // Two bullets at the same height struck in one tick
    do_reset();
    enemy_alive = 1'b0; p_x = 300; p_y = 400; fire = 1'b1;
    do_tick();
    fire = 1'b0;
    repeat (20) do_tick();
    p_x = 310; p_y = 320; fire = 1'b1;
    do_tick(); check_all();
    fire = 1'b0; enemy_x = 310; enemy_y = 280; enemy_alive = 1'b1;
    do_tick(); check_all();

    // boom clears the pool and blocks spawning while high
    do_reset();
    enemy_alive = 1'b0; p_x = 300; p_y = 400; fire = 1'b1;
    repeat (43) do_tick();
    check_all();
    set_boom(1'b1);
    check_all();
    scan(314, 392, "boom_cleared");
    repeat (25) begin do_tick(); check_all(); end
    set_boom(1'b0);
    do_tick(); check_all();

    // Randomised play against the model
    for (int t = 0; t < 250; t++) begin
      p_x = 10'($urandom_range(0, 1023));
      p_y = 10'($urandom_range(0, 479));
      fire = ($urandom_range(0, 9) < 7);
      enemy_alive = $urandom_range(0, 1);
      enemy_x = 10'((int'(p_x) + 1024 - 20 + $urandom_range(0, 60)) % 1024);
      enemy_y = 10'($urandom_range(0, int'(p_y)));
      if ($urandom_range(0, 19) == 0) set_boom(1'b1);
      do_tick();
      if (boom) set_boom(1'b0);
      check_all();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
